// File: rtl/seq_add_sub_pkg.sv
// Shared definitions for the sequential chunked adder/subtractor:
// control FSM state encoding and default operand/chunk widths.
package seq_add_sub_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_e;

    localparam int DEFAULT_WIDTH = 16;
    localparam int DEFAULT_CHUNK = 4;

endpackage : seq_add_sub_pkg

// File: rtl/seq_add_sub_add_chunk.sv
// CHUNK-bit combinational full adder used once per RUN cycle by seq_add_sub.
// Besides the sum and carry out it reports the carry into the chunk MSB,
// which the top uses to form signed overflow on the last chunk.
module add_chunk
    import seq_add_sub_pkg::*;
#(
    parameter int CHUNK = DEFAULT_CHUNK
) (
    input  logic [CHUNK-1:0] a_i,
    input  logic [CHUNK-1:0] b_i,
    input  logic             ci_i,
    output logic [CHUNK-1:0] s_o,
    output logic             co_o,
    output logic             cmsb_o
);

    logic [CHUNK:0] full_s;

    // Add the chunk; the MSB carry-in is recovered from the MSB sum bit
    // (s = a ^ b ^ cin), which also holds for CHUNK == 1.
    always_comb begin
        full_s = {1'b0, a_i} + {1'b0, b_i} + {{CHUNK{1'b0}}, ci_i};
        s_o    = full_s[CHUNK-1:0];
        co_o   = full_s[CHUNK];
        cmsb_o = full_s[CHUNK-1] ^ a_i[CHUNK-1] ^ b_i[CHUNK-1];
    end

endmodule : add_chunk

// File: rtl/seq_add_sub.sv
// Sequential add/subtract unit: processes CHUNK bits per clock, LSB first,
// reusing one add_chunk instance. Result appears WIDTH/CHUNK edges after
// the accepting edge and is held until the consumer takes it.
// Optional feature: define SEQ_ADD_SUB_SAT_EN to saturate the result on
// signed overflow (default build wraps modulo 2^WIDTH).
module seq_add_sub
    import seq_add_sub_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH,
    parameter int CHUNK = DEFAULT_CHUNK
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             c,
    output logic             v,
    output logic             z
);

    localparam int NCHUNK = WIDTH / CHUNK;
    localparam int IDXW   = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
    localparam logic [IDXW-1:0] LAST_IDX = IDXW'(NCHUNK - 1);

    generate
        if ((CHUNK < 1) || (WIDTH < CHUNK) || ((WIDTH % CHUNK) != 0)) begin : g_bad_cfg
            $error("seq_add_sub: WIDTH must be a positive multiple of CHUNK");
        end
    endgenerate

`ifdef SEQ_ADD_SUB_SAT_EN
    localparam logic [WIDTH-1:0] SAT_MIN = {1'b1, {(WIDTH-1){1'b0}}};
    localparam logic [WIDTH-1:0] SAT_MAX = {1'b0, {(WIDTH-1){1'b1}}};
    logic             a_msb_q;
`endif

    state_e           state_q;
    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] b_q;
    logic             carry_q;
    logic [IDXW-1:0]  idx_q;
    logic [WIDTH-1:0] sum_q;
    logic             c_q;
    logic             v_q;
    logic             z_q;

    logic [CHUNK-1:0]       ck_s;
    logic                   co_s;
    logic                   cmsb_s;
    logic [WIDTH+CHUNK-1:0] shift_s;
    logic [WIDTH-1:0]       sum_shift_d;
    logic [WIDTH-1:0]       sum_final_d;
    logic                   v_d;
    logic                   z_d;

    // Operands are shifted right each RUN cycle, so the active chunk is
    // always the low CHUNK bits.
    add_chunk #(
        .CHUNK (CHUNK)
    ) u_add_chunk (
        .a_i    (a_q[CHUNK-1:0]),
        .b_i    (b_q[CHUNK-1:0]),
        .ci_i   (carry_q),
        .s_o    (ck_s),
        .co_o   (co_s),
        .cmsb_o (cmsb_s)
    );

    // Shift the new chunk in at the top of the result; after the last chunk the word is aligned.
    always_comb begin
        shift_s     = {ck_s, sum_q};
        sum_shift_d = shift_s[WIDTH+CHUNK-1:CHUNK];
        v_d         = co_s ^ cmsb_s;
`ifdef SEQ_ADD_SUB_SAT_EN
        if (v_d) begin
            sum_final_d = a_msb_q ? SAT_MIN : SAT_MAX;
        end else begin
            sum_final_d = sum_shift_d;
        end
`else
        sum_final_d = sum_shift_d;
`endif
        z_d = (sum_final_d == {WIDTH{1'b0}});
    end

    // Control FSM and datapath registers; reset wins over any handshake.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            a_q     <= {WIDTH{1'b0}};
            b_q     <= {WIDTH{1'b0}};
            carry_q <= 1'b0;
            idx_q   <= {IDXW{1'b0}};
            sum_q   <= {WIDTH{1'b0}};
            c_q     <= 1'b0;
            v_q     <= 1'b0;
            z_q     <= 1'b0;
`ifdef SEQ_ADD_SUB_SAT_EN
            a_msb_q <= 1'b0;
`endif
        end else begin
            case (state_q)
                IDLE: begin
                    if (in_valid) begin
                        // Subtraction is A + ~B + 1; cin only matters for add.
                        a_q     <= a;
                        b_q     <= b ^ {WIDTH{sub}};
                        carry_q <= sub ? 1'b1 : cin;
                        idx_q   <= {IDXW{1'b0}};
`ifdef SEQ_ADD_SUB_SAT_EN
                        a_msb_q <= a[WIDTH-1];
`endif
                        state_q <= RUN;
                    end
                end
                RUN: begin
                    a_q     <= a_q >> CHUNK;
                    b_q     <= b_q >> CHUNK;
                    carry_q <= co_s;
                    idx_q   <= idx_q + IDXW'(1);
                    if (idx_q == LAST_IDX) begin
                        sum_q   <= sum_final_d;
                        c_q     <= co_s;
                        v_q     <= v_d;
                        z_q     <= z_d;
                        state_q <= DONE;
                    end else begin
                        sum_q   <= sum_shift_d;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        state_q <= IDLE;
                    end
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign in_ready  = (state_q == IDLE);
    assign out_valid = (state_q == DONE);
    assign sum       = sum_q;
    assign c         = c_q;
    assign v         = v_q;
    assign z         = z_q;

endmodule : seq_add_sub

// File: tb/tb_seq_add_sub.sv
// Scoreboard bench for seq_add_sub: WIDTH=8/CHUNK=2 main instance plus a
// WIDTH=CHUNK=4 instance for the single-cycle corner.
`timescale 1ns/1ps
module tb_seq_add_sub;

    localparam int W  = 8;
    localparam int C  = 2;
    localparam int N  = W / C;
    localparam int W1 = 4;

    typedef struct packed {
        logic [15:0] sum;
        logic        c;
        logic        v;
        logic        z;
    } exp_t;

    logic clk = 1'b0;
    logic rst, in_valid, cin, sub, out_ready;
    logic [W-1:0] a, b, sum;
    logic in_ready, out_valid, c, v, z;

    logic in_valid1, cin1, sub1, out_ready1;
    logic [W1-1:0] a1, b1, sum1;
    logic in_ready1, out_valid1, c1, v1, z1;

    int   n_tests = 0;
    int   n_fail  = 0;
    exp_t exp_q[$];

    always #5 clk = ~clk;

    seq_add_sub #(.WIDTH(W), .CHUNK(C)) u_dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .a(a), .b(b), .cin(cin), .sub(sub),
        .out_valid(out_valid), .out_ready(out_ready),
        .sum(sum), .c(c), .v(v), .z(z)
    );

    seq_add_sub #(.WIDTH(W1), .CHUNK(W1)) u_dut1 (
        .clk(clk), .rst(rst), .in_valid(in_valid1), .in_ready(in_ready1),
        .a(a1), .b(b1), .cin(cin1), .sub(sub1),
        .out_valid(out_valid1), .out_ready(out_ready1),
        .sum(sum1), .c(c1), .v(v1), .z(z1)
    );

    // Reference: plain integer arithmetic on w-bit operands.
    function automatic exp_t model(input int w, input longint ua, input longint ub,
                                   input logic ci, input logic sb);
        longint modv, half, sa, sbv, res, wrap;
        exp_t   e;
        modv = longint'(1) << w;
        half = modv / 2;
        sa   = (ua >= half) ? ua - modv : ua;
        sbv  = (ub >= half) ? ub - modv : ub;
        if (sb) begin
            wrap = (((ua - ub) % modv) + modv) % modv;
            e.c  = (ua >= ub);
            res  = sa - sbv;
        end else begin
            wrap = (ua + ub + longint'(ci)) % modv;
            e.c  = ((ua + ub + longint'(ci)) >= modv);
            res  = sa + sbv + longint'(ci);
        end
        e.v = (res < -half) || (res > half - 1);
`ifdef SEQ_ADD_SUB_SAT_EN
        if (e.v) begin
            wrap = (sa < 0) ? half : half - 1;
        end
`endif
        e.sum = 16'(wrap);
        e.z   = (wrap == 0);
        return e;
    endfunction

    task automatic check(input string name, input longint act, input longint req);
        n_tests++;
        if (act != req) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
        end
    endtask

    // Monitor: pop and compare whenever the main DUT hands over a result.
    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge clk);
            if (!rst && out_valid && out_ready) begin
                check("out_valid_has_pending_op", longint'(exp_q.size() > 0), 1);
                if (exp_q.size() > 0) begin
                    e = exp_q.pop_front();
                    check("sum", longint'(sum), longint'(e.sum[W-1:0]));
                    check("c",   longint'(c),   longint'(e.c));
                    check("v",   longint'(v),   longint'(e.v));
                    check("z",   longint'(z),   longint'(e.z));
                end
            end
        end
    end

    // One operation on the main DUT: accept, scramble inputs while running,
    // check latency, stall for 'stall' cycles, then hand the result over.
    task automatic do_op(input logic [W-1:0] ta, input logic [W-1:0] tb_v,
                         input logic tci, input logic tsub, input int stall);
        int lat;
        logic [W+2:0] hold;
        @(negedge clk);
        check("in_ready_idle", longint'(in_ready), 1);
        a = ta; b = tb_v; cin = tci; sub = tsub; in_valid = 1'b1; out_ready = 1'b0;
        exp_q.push_back(model(W, longint'(ta), longint'(tb_v), tci, tsub));
        @(posedge clk); #1;
        lat = 0;
        while (!out_valid && lat < 20) begin
            a = W'($urandom); b = W'($urandom);
            cin = 1'($urandom); sub = 1'($urandom); in_valid = 1'($urandom);
            @(posedge clk); #1;
            lat++;
        end
        in_valid = 1'b0;
        check("latency", longint'(lat), longint'(N));
        hold = {sum, c, v, z};
        for (int i = 0; i < stall; i++) begin
            @(posedge clk); #1;
            check("stall_hold", longint'({sum, c, v, z}), longint'(hold));
            check("stall_valid_ready", longint'({out_valid, in_ready}), 2);
        end
        out_ready = 1'b1; in_valid = 1'b1; a = W'($urandom); b = W'($urandom);
        @(posedge clk); #1;
        out_ready = 1'b0; in_valid = 1'b0;
        check("idle_after_handshake", longint'({out_valid, in_ready}), 1);
    endtask

    initial begin : watchdog
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin : stimulus
        exp_t e1;
        int   seen;
        rst = 1'b1; in_valid = 1'b0; a = '0; b = '0; cin = 1'b0; sub = 1'b0; out_ready = 1'b0;
        in_valid1 = 1'b0; a1 = '0; b1 = '0; cin1 = 1'b0; sub1 = 1'b0; out_ready1 = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check("rst_valid_ready",  longint'({out_valid, in_ready}), 1);
        check("rst_outputs",      longint'({sum, c, v, z}), 0);
        check("rst1_valid_ready", longint'({out_valid1, in_ready1}), 1);
        check("rst1_outputs",     longint'({sum1, c1, v1, z1}), 0);
        rst = 1'b0;

        // Directed vectors: overflow, wrap to zero, subtraction cases, long stall.
        do_op(8'h7F, 8'h01, 1'b0, 1'b0, 0);
        do_op(8'hFF, 8'h01, 1'b0, 1'b0, 1);
        do_op(8'h05, 8'h07, 1'b0, 1'b1, 0);
        do_op(8'h80, 8'h01, 1'b1, 1'b1, 2);
        do_op(8'h00, 8'h00, 1'b0, 1'b1, 0);
        do_op(8'hAA, 8'h55, 1'b1, 1'b0, 5);

        // Reset while chunk 1 is being processed abandons the operation.
        @(negedge clk);
        a = 8'h11; b = 8'h22; cin = 1'b0; sub = 1'b0; in_valid = 1'b1;
        exp_q.push_back(model(W, 64'h11, 64'h22, 1'b0, 1'b0));
        @(posedge clk); #1;
        in_valid = 1'b0;
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        void'(exp_q.pop_back());
        check("rst_run_valid_ready", longint'({out_valid, in_ready}), 1);
        check("rst_run_outputs",     longint'({sum, c, v, z}), 0);
        seen = 0;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk); #1;
            if (out_valid) seen = 1;
        end
        check("rst_no_out_valid", longint'(seen), 0);
        do_op(8'h03, 8'h04, 1'b0, 1'b0, 1);

        // Random operations with random stalls.
        for (int i = 0; i < 40; i++) begin
            do_op(W'($urandom), W'($urandom), 1'($urandom), 1'($urandom),
                  int'($urandom_range(0, 3)));
        end
        check("queue_drained", longint'(exp_q.size()), 0);

        // WIDTH == CHUNK: one RUN cycle, result one edge after accept.
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (i == 0) begin
                a1 = 4'hF; b1 = 4'h1; cin1 = 1'b1; sub1 = 1'b0;
            end else begin
                a1 = W1'($urandom); b1 = W1'($urandom); cin1 = 1'($urandom); sub1 = 1'($urandom);
            end
            e1 = model(W1, longint'(a1), longint'(b1), cin1, sub1);
            in_valid1 = 1'b1;
            @(posedge clk); #1;
            in_valid1 = 1'b0;
            check("w1_not_ready_after_accept", longint'(in_ready1), 0);
            @(posedge clk); #1;
            check("w1_latency", longint'(out_valid1), 1);
            check("w1_sum", longint'(sum1), longint'(e1.sum[W1-1:0]));
            check("w1_cvz", longint'({c1, v1, z1}), longint'({e1.c, e1.v, e1.z}));
            @(posedge clk); #1;
            check("w1_idle", longint'({out_valid1, in_ready1}), 1);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule : tb_seq_add_sub

// File: doc/seq_add_sub.md
SEQ_ADD_SUB -- requirements
Module: seq_add_sub

Interface
REQ-001 SHALL have parameter WIDTH, default 16, operand/result width in bits.
REQ-002 SHALL have parameter CHUNK, default 4, bits processed per clock; WIDTH % CHUNK != 0 SHALL fail elaboration.
REQ-003 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-004 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-005 SHALL have port in_valid  input  1  operands and mode valid.
REQ-006 SHALL have port in_ready  output  1  block can accept a new operation.
REQ-007 SHALL have port a  input  WIDTH  operand A, two's complement or unsigned.
REQ-008 SHALL have port b  input  WIDTH  operand B.
REQ-009 SHALL have port cin  input  1  carry-in, used only when sub=0.
REQ-010 SHALL have port sub  input  1  0 = A+B+cin, 1 = A-B.
REQ-011 SHALL have port out_valid  output  1  result valid.
REQ-012 SHALL have port out_ready  input  1  consumer accepts result.
REQ-013 SHALL have port sum  output  WIDTH  result.
REQ-014 SHALL have port c  output  1  carry out of MSB (unsigned carry; for sub, 1 = no borrow).
REQ-015 SHALL have port v  output  1  signed overflow.
REQ-016 SHALL have port z  output  1  sum == 0.

Function
REQ-017 SHALL implement FSM IDLE -> RUN -> DONE -> IDLE; in_ready = 1 only in IDLE.
REQ-018 SHALL accept an operation on an edge where in_valid && in_ready; SHALL latch a, b ^ {WIDTH{sub}}, carry = sub ? 1 : cin, chunk index = 0; go to RUN.
REQ-019 In RUN, each cycle SHALL add chunk k (bits k*CHUNK+CHUNK-1 : k*CHUNK, LSB first) with registered carry and store it into sum.
REQ-020 After chunk WIDTH/CHUNK-1, SHALL go to DONE; out_valid SHALL rise exactly WIDTH/CHUNK edges after the accepting edge.
REQ-021 c SHALL equal carry out of bit WIDTH-1; v SHALL equal carry into bit WIDTH-1 XOR carry out of bit WIDTH-1; z SHALL be computed on the final sum.
REQ-022 sum, c, v, z SHALL hold stable while out_valid=1 and out_ready=0.
REQ-023 In DONE, out_valid && out_ready SHALL return to IDLE; in_ready SHALL be 1 the following cycle (no same-cycle accept).
REQ-024 in_valid SHALL be ignored outside IDLE; inputs SHALL not affect an operation once accepted.
REQ-025 WIDTH == CHUNK SHALL be legal: single RUN cycle, latency 1.
REQ-026 All arithmetic SHALL wrap modulo 2^WIDTH unless REQ-030 applies.

Reset
REQ-027 rst=1 SHALL force IDLE, in_ready=1 after the edge, out_valid=0, sum=0, c=0, v=0, z=0.
REQ-028 rst asserted in RUN or DONE SHALL abandon the operation; no out_valid for it.
REQ-029 rst SHALL take priority over any simultaneous handshake.

Configuration
REQ-030 With SEQ_ADD_SUB_SAT_EN defined, on v=1 sum SHALL saturate to 0x7F..F if latched a MSB = 0, else 0x80..0; v still reports 1; c is unsaturated carry; z follows saturated sum.
REQ-031 Without SEQ_ADD_SUB_SAT_EN, sum SHALL be the wrapped result and no saturation logic SHALL exist.

Structure
REQ-032 A shared package seq_add_sub_pkg SHALL hold the FSM state enum (IDLE, RUN, DONE) and default WIDTH/CHUNK constants.
REQ-033 One sub-module add_chunk (CHUNK-bit combinational full adder: a, b, ci -> s, co, carry into MSB) SHALL be instantiated once and reused each RUN cycle.

Verification
REQ-034 WIDTH=8, CHUNK=2: a=0x7F, b=0x01, sub=0, cin=0 -> sum=0x80, c=0, v=1, z=0, out_valid 4 edges after accept (SAT_EN: sum=0x7F).
REQ-035 WIDTH=8, CHUNK=2: a=0xFF, b=0x01, sub=0, cin=0 -> sum=0x00, c=1, v=0, z=1.
REQ-036 WIDTH=8, CHUNK=4: a=0x05, b=0x07, sub=1 -> sum=0xFE, c=0, v=0; a=0x80, b=0x01, sub=1 -> sum=0x7F, v=1 (SAT_EN: 0x80).
REQ-037 out_ready held 0 for 5 cycles in DONE -> outputs stable, in_ready=0; out_ready=1 -> IDLE, in_ready=1 next cycle.
REQ-038 rst pulsed during RUN chunk 1 -> IDLE, out_valid never asserted; following op a=0x03, b=0x04 -> sum=0x07.
REQ-039 WIDTH=CHUNK=4: a=0xF, b=0x1, cin=1 -> sum=0x1, c=1, out_valid 1 edge after accept.
